// File: rtl/reg_map_pkg.sv
// Register map, bus widths and arbiter FSM encodings shared by the write arbiter.
package reg_map_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam int ADDR_EN_OUT_7_0  = 0;
  localparam int ADDR_EN_OUT_15_8 = 1;
  localparam int ADDR_EN_PWM_7_0  = 2;
  localparam int ADDR_EN_PWM_15_8 = 3;
  localparam int ADDR_PWM_DUTY    = 4;

  // Encodings double as the owner output value.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOCK0 = 2'b01,
    ST_LOCK1 = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              lock;
  } wr_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port that did not win last.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Configuration register bank with a single write port shared by SPI (port 0) and a local master (port 1).
// Optional registered readback port when REG_ARB_READBACK_EN is defined.
module reg_write_arbiter
  import reg_map_pkg::*;
#(
  parameter int MAX_ADDR     = 4,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic [1:0]        req_ready,
  output logic [1:0]        wr_err,
  output logic              lock_timeout,
  output logic [1:0]        owner,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle
`ifdef REG_ARB_READBACK_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`endif
);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t                    r_state, w_state_nxt;
  logic                          r_last_grant, w_last_nxt;
  logic [TW-1:0]                 r_tmo, w_tmo_nxt, w_tmo_inc;
  logic                          w_tmo_fire, r_lock_timeout;
  logic [1:0]                    r_wr_err;
  logic [MAX_ADDR:0][DATA_W-1:0] r_bank;

  logic [1:0] w_rr_grant, w_ready, w_hs;
  logic       w_hs_any, w_hs_port, w_lport, w_addr_bad;
  wr_req_t    w_sel;

  rr_arb2 u_rr (
    .i_valid     (req_valid),
    .i_last_grant(r_last_grant),
    .o_grant     (w_rr_grant)
  );

  // While locked only the owner can be ready; ready is held low during reset.
  always_comb begin
    w_ready = 2'b00;
    case (r_state)
      ST_IDLE:  w_ready = w_rr_grant;
      ST_LOCK0: w_ready = {1'b0, req_valid[0]};
      ST_LOCK1: w_ready = {req_valid[1], 1'b0};
      default:  w_ready = 2'b00;
    endcase
  end

  assign req_ready  = w_ready & {2{rst_n}};
  assign w_hs       = req_valid & req_ready;
  assign w_hs_any   = |w_hs;
  assign w_hs_port  = w_hs[1];
  assign w_sel      = w_hs_port ? '{addr: req1_addr, data: req1_data, lock: req_lock[1]}
                                : '{addr: req0_addr, data: req0_data, lock: req_lock[0]};
  assign w_addr_bad = w_sel.addr > ADDR_W'(MAX_ADDR);
  assign w_lport    = (r_state == ST_LOCK1);
  assign w_tmo_inc  = r_tmo + TW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_grant;
    w_tmo_nxt   = r_tmo;
    w_tmo_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmo_nxt = '0;
        if (w_hs_any) begin
          w_last_nxt = w_hs_port;
          if (w_sel.lock) w_state_nxt = w_hs_port ? ST_LOCK1 : ST_LOCK0;
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (w_hs_any) begin
          w_last_nxt = w_lport;
          w_tmo_nxt  = '0;
          if (!w_sel.lock) w_state_nxt = ST_IDLE;
        end else if (!req_valid[w_lport] && !req_lock[w_lport]) begin
          w_state_nxt = ST_IDLE;
          w_tmo_nxt   = '0;
        end else if (w_tmo_inc == TW'(LOCK_TIMEOUT)) begin
          // Owner stalled too long: hand the next tie to the other port.
          w_state_nxt = ST_IDLE;
          w_tmo_nxt   = '0;
          w_tmo_fire  = 1'b1;
          w_last_nxt  = w_lport;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_last_grant   <= 1'b1;
      r_tmo          <= '0;
      r_lock_timeout <= 1'b0;
      r_wr_err       <= 2'b00;
    end else begin
      r_state        <= w_state_nxt;
      r_last_grant   <= w_last_nxt;
      r_tmo          <= w_tmo_nxt;
      r_lock_timeout <= w_tmo_fire;
      r_wr_err       <= w_hs & {2{w_addr_bad}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= '0;
    end else if (w_hs_any && !w_addr_bad) begin
      for (int i = 0; i <= MAX_ADDR; i++)
        if (w_sel.addr == ADDR_W'(i)) r_bank[i] <= w_sel.data;
    end
  end

  assign wr_err          = r_wr_err;
  assign lock_timeout    = r_lock_timeout;
  assign owner           = r_state;
  assign en_reg_out_7_0  = r_bank[ADDR_EN_OUT_7_0];
  assign en_reg_out_15_8 = r_bank[ADDR_EN_OUT_15_8];
  assign en_reg_pwm_7_0  = r_bank[ADDR_EN_PWM_7_0];
  assign en_reg_pwm_15_8 = r_bank[ADDR_EN_PWM_15_8];
  assign pwm_duty_cycle  = r_bank[ADDR_PWM_DUTY];

`ifdef REG_ARB_READBACK_EN
  logic [DATA_W-1:0] w_rd_mux, r_rd_data;

  // Unmapped addresses fall through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i <= MAX_ADDR; i++)
      if (rd_addr == ADDR_W'(i)) w_rd_mux = r_bank[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= w_rd_mux;
  end

  assign rd_data = r_rd_data;
`endif
endmodule
